// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron scheduler slice.
//   - default neuron count and potential width
//   - scheduler state enumeration
//   - idx_width(): bits needed to address one neuron (never less than 1)
// -----------------------------------------------------------------------------
package neuron_pkg;

    localparam int N_NEURONS_DEF = 4;
    localparam int WIDTH_DEF     = 8;
    localparam int FRAME_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // A two-neuron bank still needs one address bit, so clamp at 1.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/potential_bank.sv
// -----------------------------------------------------------------------------
// potential_bank
// Membrane potential storage, N_NEURONS entries of WIDTH bits.
// Ports:
//   clk_i     rising-edge clock
//   reset_i   asynchronous active-high clear of every entry
//   we_i      write enable
//   waddr_i   write address (neuron index)
//   wdata_i   write data (new potential)
//   raddr_i   read address (neuron index)
//   rdata_o   combinational read data
// -----------------------------------------------------------------------------
module potential_bank
    import neuron_pkg::*;
#(
    parameter int N_NEURONS = N_NEURONS_DEF,
    parameter int WIDTH     = WIDTH_DEF
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             we_i,
    input  logic [idx_width(N_NEURONS)-1:0]  waddr_i,
    input  logic [WIDTH-1:0]                 wdata_i,
    input  logic [idx_width(N_NEURONS)-1:0]  raddr_i,
    output logic [WIDTH-1:0]                 rdata_o
);

    logic [WIDTH-1:0] mem_q [N_NEURONS];

    // Single write port; reset wipes every potential back to rest.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read so the datapath sees the potential in the same
    // cycle the index is presented.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/neuron_scheduler.sv
// -----------------------------------------------------------------------------
// neuron_scheduler
// Time-multiplexes N_NEURONS virtual neurons onto one shared
// synapse/adder/leak datapath. A frame of pre-synaptic spikes is latched,
// each neuron is evaluated in turn through a req/ack handshake, and the
// resulting post-synaptic spike vector is published with a one-cycle pulse.
// Ports:
//   clk_i, reset_i     clock, asynchronous active-high reset
//   frame_valid_i      new frame offered
//   frame_spikes_i     pre-synaptic spike vector of the frame
//   frame_learn_i      enable learning for the frame
//   frame_ready_o      scheduler can accept a frame
//   dp_req_o           request to the shared datapath
//   dp_neuron_o        index of the neuron under evaluation
//   dp_spikes_o        latched frame spikes
//   dp_potential_o     stored potential of dp_neuron_o
//   dp_learn_o         latched learn flag, only while requesting
//   dp_ack_i           datapath result valid
//   dp_sum_i           new potential from the datapath
//   dp_overflow_i      adder carry-out, neuron fires
//   spikes_valid_o     one-cycle pulse for a completed frame
//   spikes_o           post-synaptic spike vector of the completed frame
//   busy_o             frame in progress
// -----------------------------------------------------------------------------
module neuron_scheduler
    import neuron_pkg::*;
#(
    parameter int N_NEURONS = N_NEURONS_DEF,
    parameter int WIDTH     = WIDTH_DEF
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             frame_valid_i,
    input  logic [FRAME_W-1:0]               frame_spikes_i,
    input  logic                             frame_learn_i,
    output logic                             frame_ready_o,
    output logic                             dp_req_o,
    output logic [idx_width(N_NEURONS)-1:0]  dp_neuron_o,
    output logic [FRAME_W-1:0]               dp_spikes_o,
    output logic [WIDTH-1:0]                 dp_potential_o,
    output logic                             dp_learn_o,
    input  logic                             dp_ack_i,
    input  logic [WIDTH-1:0]                 dp_sum_i,
    input  logic                             dp_overflow_i,
    output logic                             spikes_valid_o,
    output logic [N_NEURONS-1:0]             spikes_o,
    output logic                             busy_o
);

    localparam int               IDX_W    = idx_width(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    sched_state_e         state_q;
    logic [IDX_W-1:0]     index_q;
    logic [IDX_W-1:0]     index_d;
    logic [FRAME_W-1:0]   spikes_lat_q;
    logic                 learn_lat_q;
    logic [N_NEURONS-1:0] spikes_q;
    logic [N_NEURONS-1:0] spikes_d;
    logic                 spikes_valid_q;
    logic                 dp_req_q;
    logic                 frame_ready_q;

    logic                 commit;
    logic [WIDTH-1:0]     bank_wdata;
    logic [WIDTH-1:0]     bank_rdata;

    // An acknowledge only counts while a request is outstanding.
    assign commit = dp_req_q && dp_ack_i;

    // A firing neuron restarts from zero instead of keeping the wrapped sum.
    assign bank_wdata = dp_overflow_i ? '0 : dp_sum_i;

    // Next index and the spike vector with the current neuron's result folded in.
    always_comb begin
        index_d           = index_q + IDX_W'(1);
        spikes_d          = spikes_q;
        spikes_d[index_q] = dp_overflow_i;
    end

    potential_bank #(
        .N_NEURONS (N_NEURONS),
        .WIDTH     (WIDTH)
    ) u_bank (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (commit),
        .waddr_i (index_q),
        .wdata_i (bank_wdata),
        .raddr_i (index_q),
        .rdata_o (bank_rdata)
    );

    // Frame sequencer. frame_ready stays low through reset and rises one
    // cycle after release; it drops as soon as a frame is taken so a frame
    // held on the input during RUN/DONE is never accepted twice.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            index_q        <= '0;
            spikes_lat_q   <= '0;
            learn_lat_q    <= 1'b0;
            spikes_q       <= '0;
            spikes_valid_q <= 1'b0;
            dp_req_q       <= 1'b0;
            frame_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    spikes_valid_q <= 1'b0;
                    if (frame_valid_i && frame_ready_q) begin
                        spikes_lat_q  <= frame_spikes_i;
                        learn_lat_q   <= frame_learn_i;
                        spikes_q      <= '0;
                        index_q       <= '0;
                        dp_req_q      <= 1'b1;
                        frame_ready_q <= 1'b0;
                        state_q       <= RUN;
                    end else begin
                        frame_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (commit) begin
                        spikes_q <= spikes_d;
                        if (index_q == LAST_IDX) begin
                            dp_req_q       <= 1'b0;
                            spikes_valid_q <= 1'b1;
                            state_q        <= DONE;
                        end else begin
                            index_q <= index_d;
                        end
                    end
                end
                DONE: begin
                    spikes_valid_q <= 1'b0;
                    frame_ready_q  <= 1'b1;
                    index_q        <= '0;
                    state_q        <= IDLE;
                end
                default: begin
                    spikes_valid_q <= 1'b0;
                    dp_req_q       <= 1'b0;
                    frame_ready_q  <= 1'b0;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

    assign frame_ready_o  = frame_ready_q;
    assign dp_req_o       = dp_req_q;
    assign dp_neuron_o    = index_q;
    assign dp_spikes_o    = spikes_lat_q;
    assign dp_potential_o = bank_rdata;
    assign dp_learn_o     = dp_req_q && learn_lat_q;
    assign spikes_valid_o = spikes_valid_q;
    assign spikes_o       = spikes_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// tb_neuron_scheduler
// Self-checking bench for neuron_scheduler. The bench plays the shared
// datapath, choosing ack delay, sum and overflow per neuron, and keeps its
// own array of expected potentials plus the expected spike vector per frame.
// -----------------------------------------------------------------------------
module tb_neuron_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         frame_valid;
    logic [7:0]   frame_spikes;
    logic         frame_learn;
    logic         frame_ready;
    logic         dp_req;
    logic [1:0]   dp_neuron;
    logic [7:0]   dp_spikes;
    logic [W-1:0] dp_potential;
    logic         dp_learn;
    logic         dp_ack;
    logic [W-1:0] dp_sum;
    logic         dp_overflow;
    logic         spikes_valid;
    logic [N-1:0] spikes;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Expected stored potential per neuron.
    logic [W-1:0] model [N];

    neuron_scheduler #(
        .N_NEURONS (N),
        .WIDTH     (W)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .frame_valid_i  (frame_valid),
        .frame_spikes_i (frame_spikes),
        .frame_learn_i  (frame_learn),
        .frame_ready_o  (frame_ready),
        .dp_req_o       (dp_req),
        .dp_neuron_o    (dp_neuron),
        .dp_spikes_o    (dp_spikes),
        .dp_potential_o (dp_potential),
        .dp_learn_o     (dp_learn),
        .dp_ack_i       (dp_ack),
        .dp_sum_i       (dp_sum),
        .dp_overflow_i  (dp_overflow),
        .spikes_valid_o (spikes_valid),
        .spikes_o       (spikes),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the design stops responding.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge; asserts reset, checks the cleared outputs,
    // releases reset and checks frame_ready comes back one cycle later.
    task automatic resetDut();
        reset = 1'b1;
        #1;
        checkOutput("rst_dp_req", dp_req, 0);
        checkOutput("rst_dp_learn", dp_learn, 0);
        checkOutput("rst_spikes_valid", spikes_valid, 0);
        checkOutput("rst_spikes", spikes, 0);
        checkOutput("rst_frame_ready", frame_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_dp_neuron", dp_neuron, 0);
        checkOutput("rst_dp_spikes", dp_spikes, 0);
        checkOutput("rst_dp_potential", dp_potential, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;
        #1;
        checkOutput("rst_release_ready", frame_ready, 0);
        @(negedge clk);
        checkOutput("post_rst_ready", frame_ready, 1);
        checkOutput("post_rst_busy", busy, 0);
    endtask

    // Runs one frame from a falling edge while idle and ready, ending on the
    // falling edge after the scheduler is back in IDLE.
    // delayMode/sumMode/ovfMode: >=0 fixed value (ovfMode is a neuron mask),
    // <0 randomised per neuron. hold keeps frame_valid high with noisy data.
    task automatic applyStimulus(input logic [7:0] spk, input bit learn, input int delayMode,
                                 input int sumMode, input int ovfMode, input bit hold);
        int           d;
        logic [W-1:0] sum;
        bit           ovf;
        logic [N-1:0] expSpk;
        checkOutput("ready_before_accept", frame_ready, 1);
        checkOutput("busy_idle", busy, 0);
        frame_valid  = 1'b1;
        frame_spikes = spk;
        frame_learn  = learn;
        @(posedge clk);
        expSpk = '0;
        for (int n = 0; n < N; n++) begin
            d   = (delayMode >= 0) ? delayMode : int'($urandom_range(0, 3));
            sum = (sumMode >= 0) ? sumMode[W-1:0] : W'($urandom_range(0, 255));
            ovf = (ovfMode >= 0) ? ovfMode[n] : ($urandom_range(0, 3) == 0);
            for (int w = 0; w <= d; w++) begin
                @(negedge clk);
                if (hold) begin
                    frame_valid  = 1'b1;
                    frame_spikes = 8'($urandom);
                    frame_learn  = 1'($urandom);
                end else begin
                    frame_valid = 1'b0;
                end
                checkOutput("dp_req", dp_req, 1);
                checkOutput("dp_neuron", dp_neuron, n);
                checkOutput("dp_potential", dp_potential, model[n]);
                checkOutput("dp_spikes", dp_spikes, spk);
                checkOutput("dp_learn", dp_learn, learn);
                checkOutput("ready_run", frame_ready, 0);
                checkOutput("spikes_valid_run", spikes_valid, 0);
                checkOutput("busy_run", busy, 1);
                dp_ack      = (w == d);
                dp_sum      = (w == d) ? sum : W'($urandom);
                dp_overflow = (w == d) ? ovf : 1'($urandom);
                @(posedge clk);
            end
            if (ovf) begin
                model[n]  = '0;
                expSpk[n] = 1'b1;
            end else begin
                model[n] = sum;
            end
        end
        @(negedge clk);
        // Acks with no request outstanding must not touch the bank.
        dp_ack      = 1'($urandom);
        dp_sum      = W'($urandom);
        dp_overflow = 1'($urandom);
        if (hold) frame_spikes = 8'($urandom);
        else      frame_valid  = 1'b0;
        checkOutput("spikes_valid_done", spikes_valid, 1);
        checkOutput("spikes_done", spikes, expSpk);
        checkOutput("dp_req_done", dp_req, 0);
        checkOutput("dp_learn_done", dp_learn, 0);
        checkOutput("busy_done", busy, 1);
        checkOutput("ready_done", frame_ready, 0);
        @(posedge clk);
        @(negedge clk);
        dp_ack = 1'b0;
        checkOutput("spikes_valid_pulse", spikes_valid, 0);
        checkOutput("spikes_held", spikes, expSpk);
        checkOutput("busy_after", busy, 0);
        checkOutput("ready_after", frame_ready, 1);
        checkOutput("dp_req_after", dp_req, 0);
    endtask

    initial begin
        reset        = 1'b1;
        frame_valid  = 1'b0;
        frame_spikes = '0;
        frame_learn  = 1'b0;
        dp_ack       = 1'b0;
        dp_sum       = '0;
        dp_overflow  = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;

        @(negedge clk);
        resetDut();

        // Plain accumulate, immediate acks: spikes_valid 5 cycles after accept.
        applyStimulus(8'hA5, 1'b0, 0, 'h10, 0, 1'b0);
        // Neuron 2 fires: its potential restarts from zero.
        applyStimulus(8'h3C, 1'b0, 0, 'h05, 'b0100, 1'b0);
        // Slow datapath with learning on; bank must read {5,5,0,5} here.
        applyStimulus(8'h81, 1'b1, 3, -1, -1, 1'b0);
        // frame_valid held high through the frame, then a back-to-back frame.
        applyStimulus(8'h5A, 1'b1, -1, -1, -1, 1'b1);
        applyStimulus(8'hC3, 1'b0, -1, -1, -1, 1'b0);

        for (int f = 0; f < 20; f++) begin
            applyStimulus(8'($urandom), 1'($urandom), -1, -1, -1, ($urandom_range(0, 4) == 0));
        end

        // Reset while neuron 1 is waiting for its ack.
        frame_valid  = 1'b1;
        frame_spikes = 8'h77;
        frame_learn  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_valid = 1'b0;
        dp_ack      = 1'b1;
        dp_sum      = 8'h33;
        dp_overflow = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dp_ack = 1'b0;
        checkOutput("midrun_neuron", dp_neuron, 1);
        checkOutput("midrun_req", dp_req, 1);
        resetDut();
        repeat (6) begin
            @(negedge clk);
            checkOutput("no_pulse_after_reset", spikes_valid, 0);
        end
        // Bank must have been wiped: every neuron reads zero again.
        applyStimulus(8'h11, 1'b1, -1, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_scheduler.md
NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 Parameter N_NEURONS, 4, number of virtual neurons time-multiplexed onto the one shared synapse/adder/leak datapath (2..16).
REQ-002 Parameter WIDTH, 8, membrane potential and datapath sum width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous and active-high.
REQ-005 Port frame_valid  input  1  new input spike frame offered.
REQ-006 Port frame_spikes  input  8  pre-synaptic spike vector for the frame.
REQ-007 Port frame_learn  input  1  enable STDP learning for this frame.
REQ-008 Port frame_ready  output  1  scheduler can accept a frame.
REQ-009 Port dp_req  output  1  request to the shared datapath.
REQ-010 Port dp_neuron  output  log2(N_NEURONS)  index of the neuron being evaluated.
REQ-011 Port dp_spikes  output  8  latched frame_spikes driven to the datapath.
REQ-012 Port dp_potential  output  WIDTH  stored potential of dp_neuron.
REQ-013 Port dp_learn  output  1  latched frame_learn, qualified by dp_req.
REQ-014 Port dp_ack  input  1  datapath result valid this cycle.
REQ-015 Port dp_sum  input  WIDTH  new potential (decayed potential plus weighted inputs).
REQ-016 Port dp_overflow  input  1  adder carry-out; a 1 means the neuron spikes.
REQ-017 Port spikes_valid  output  1  one-cycle pulse marking a completed frame.
REQ-018 Port spikes  output  N_NEURONS  post-synaptic spike vector of the completed frame.
REQ-019 Port busy  output  1  high while a frame is in progress.

Function
REQ-020 States: IDLE, RUN, DONE.
REQ-021 IDLE: frame_ready=1; on frame_valid, latch frame_spikes and frame_learn, clear the spike vector, set index=0, go to RUN.
REQ-022 RUN: dp_req=1, dp_neuron=index, dp_potential=bank[index]; dp_req holds until dp_ack, and dp_neuron/dp_potential stay stable while waiting.
REQ-023 A cycle with dp_req&&dp_ack commits the result: if dp_overflow=1, bank[index]<=0 and spikes[index]<=1; otherwise bank[index]<=dp_sum and spikes[index]<=0.
REQ-024 On commit with index=N_NEURONS-1, go to DONE; otherwise index increments and RUN continues.
REQ-025 DONE: spikes_valid=1 for exactly one cycle, spikes held until the next frame is accepted, next state IDLE.
REQ-026 With dp_ack tied high, latency is as follows: frame accepted at cycle T, commits at T+1..T+N, spikes_valid at T+N+1, frame_ready again at T+N+2.
REQ-027 frame_ready=0 and frame_valid is ignored in RUN and DONE; no frame is lost or queued.
REQ-028 dp_ack is ignored when dp_req=0.
REQ-029 Arithmetic: potentials are unsigned WIDTH-bit; the scheduler never adds, it only stores dp_sum; no wrap is stored on overflow (reset to 0 instead).
REQ-030 busy = (state != IDLE).
REQ-031 dp_learn = dp_req && latched_learn.

Reset
REQ-032 Asserting reset immediately forces state=IDLE, index=0, all bank entries=0, spikes=0, spikes_valid=0, dp_req=0, dp_learn=0, latched regs=0, frame_ready=0.
REQ-033 After reset deasserts, frame_ready=1 on the following cycle; a frame interrupted by reset is discarded without a spikes_valid pulse.

Structure
REQ-034 Shared package neuron_pkg holds the state enum, N_NEURONS/WIDTH defaults and the index width function.
REQ-035 The potential storage is one sub-module, potential_bank: N_NEURONS x WIDTH, one write port, one async read port, async clear on reset.

Verification
REQ-036 dp_ack=1, dp_sum=8'h10, dp_overflow=0 for all neurons, one frame accepted at cycle T -> spikes_valid at T+5, spikes=4'b0000, bank={10,10,10,10}.
REQ-037 Overflow on neuron 2 only (dp_overflow=1, dp_sum=8'h05) -> spikes=4'b0100, bank[2]=0, next frame dp_potential=0 for neuron 2.
REQ-038 dp_ack delayed 3 cycles per neuron -> dp_req, dp_neuron and dp_potential stay stable while waiting; spikes_valid at T+1+4*4.
REQ-039 frame_valid held high through RUN with frame_spikes changing -> only the first frame is accepted, dp_spikes constant; second accept at T+N+2.
REQ-040 reset asserted during RUN at index 1 -> dp_req drops the same cycle, no spikes_valid, all potentials read 0 on the next frame.
REQ-041 frame_learn=1 -> dp_learn=1 exactly in cycles where dp_req=1; frame_learn=0 -> dp_learn is never 1.
